// File: rtl/vga_scan_gen_if.sv
// ---------------------------------------------------------------------------
// vga_scan_gen_if
//   Bundle between the raster scan generator, the pixel source it addresses
//   and the VGA connector it drives.
//
//   display_addr  {h_cnt[10:0], v_cnt[10:0]} current scan position
//   display_data  3-bit {r,g,b} returned combinationally by the pixel source
//   vga_hsync     horizontal sync
//   vga_vsync     vertical sync
//   vga_r/g/b     colour bits, zero while blanking
//   frame_start   one-clock pulse aligned with the (0,0) output of each frame
//
//   master : the scan generator (drives address, syncs and colour)
//   slave  : the pixel source / display side
// ---------------------------------------------------------------------------
interface vga_scan_gen_if;
    logic [21:0] display_addr;
    logic [2:0]  display_data;
    logic        vga_hsync;
    logic        vga_vsync;
    logic        vga_r;
    logic        vga_g;
    logic        vga_b;
    logic        frame_start;

    modport master (
        output display_addr,
        input  display_data,
        output vga_hsync,
        output vga_vsync,
        output vga_r,
        output vga_g,
        output vga_b,
        output frame_start
    );

    modport slave (
        input  display_addr,
        output display_data,
        input  vga_hsync,
        input  vga_vsync,
        input  vga_r,
        input  vga_g,
        input  vga_b,
        input  frame_start
    );
endinterface

// File: rtl/vga_scan_gen.sv
// ---------------------------------------------------------------------------
// vga_scan_gen
//   Raster scan generator. Walks 11-bit horizontal/vertical counters, presents
//   the position to a pixel source as display_addr, samples the returned
//   colour, blanks it outside the visible window and emits pixel-aligned
//   RGB / HSYNC / VSYNC / frame_start one clock after the address.
//   Counter origin (0,0) is the first clock of the HSYNC/VSYNC pulses.
//
// Ports
//   sysclk  in   pixel clock
//   rst_n   in   asynchronous, active-low reset
//   vga     vga_scan_gen_if.master : display_addr / display_data /
//           vga_hsync / vga_vsync / vga_r / vga_g / vga_b / frame_start
//
// Build option
//   VGA_TEST_PATTERN_EN : when defined, display_data is ignored and the
//   visible window shows 8 vertical colour bars (bar 0 = 3'b000 on the left,
//   bar 7 = 3'b111 on the right). Timing and latency are unchanged.
// ---------------------------------------------------------------------------
module vga_scan_gen #(
    parameter int H_SYNC   = 120,
    parameter int H_BACK   = 64,
    parameter int H_ACTIVE = 800,
    parameter int H_FRONT  = 56,
    parameter int V_SYNC   = 6,
    parameter int V_BACK   = 23,
    parameter int V_ACTIVE = 600,
    parameter int V_FRONT  = 37,
    parameter bit SYNC_POL = 1'b1
) (
    input  logic              sysclk,
    input  logic              rst_n,
    vga_scan_gen_if.master    vga
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_SYNC_END = 11'(H_SYNC);
    localparam logic [10:0] V_SYNC_END = 11'(V_SYNC);
    localparam logic [10:0] X_FIRST    = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] X_LAST     = 11'(H_SYNC + H_BACK + H_ACTIVE - 1);
    localparam logic [10:0] Y_FIRST    = 11'(V_SYNC + V_BACK);
    localparam logic [10:0] Y_LAST     = 11'(V_SYNC + V_BACK + V_ACTIVE - 1);

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic [10:0] h_cnt_q, h_cnt_d;
    logic [10:0] v_cnt_q, v_cnt_d;
    logic [2:0]  rgb_q, rgb_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        frame_start_q, frame_start_d;

    logic        active;
    logic [2:0]  pixel;

    // ---------------------------------------------------------------------
    // Scan counters: h wraps every line, v steps on the h wrap and wraps on
    // the same clock at the end of the frame.
    // ---------------------------------------------------------------------
    always_comb begin
        h_cnt_d = h_cnt_q + 11'd1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            if (v_cnt_q == V_LAST) begin
                v_cnt_d = '0;
            end else begin
                v_cnt_d = v_cnt_q + 11'd1;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Pixel source selection
    // ---------------------------------------------------------------------
    assign active = (h_cnt_q >= X_FIRST) && (h_cnt_q <= X_LAST) &&
                    (v_cnt_q >= Y_FIRST) && (v_cnt_q <= Y_LAST);

`ifdef VGA_TEST_PATTERN_EN
    localparam logic [10:0] BAR_W = 11'(H_ACTIVE / 8);
    logic [10:0] x_off;

    // Offset only matters inside the visible window, where it never underflows.
    assign x_off = h_cnt_q - X_FIRST;
    assign pixel = 3'(x_off / BAR_W);
`else
    assign pixel = vga.display_data;
`endif

    // ---------------------------------------------------------------------
    // Output stage inputs, computed from the position currently on
    // display_addr so every output lands exactly one clock later.
    // The blanking mux keeps an undriven/X colour source off the outputs.
    // ---------------------------------------------------------------------
    always_comb begin
        rgb_d         = active ? pixel : 3'b000;
        hsync_d       = (h_cnt_q < H_SYNC_END) ? SYNC_POL : ~SYNC_POL;
        // Depends only on v_cnt, which changes only on the h wrap, so vsync
        // edges always line up with the hsync leading edge.
        vsync_d       = (v_cnt_q < V_SYNC_END) ? SYNC_POL : ~SYNC_POL;
        frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            rgb_q         <= 3'b000;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            frame_start_q <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            rgb_q         <= rgb_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign vga.display_addr = {h_cnt_q, v_cnt_q};
    assign vga.vga_r        = rgb_q[2];
    assign vga.vga_g        = rgb_q[1];
    assign vga.vga_b        = rgb_q[0];
    assign vga.vga_hsync    = hsync_q;
    assign vga.vga_vsync    = vsync_q;
    assign vga.frame_start  = frame_start_q;

endmodule

// File: tb/tb_vga_scan_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_scan_gen
//   Two generators share clock and reset: dut_a with the default 800x600@72
//   timing, dut_b with a tiny raster and active-low syncs so whole frames and
//   frame wraps fit in a short run. A reference model maps the number of
//   clocks since reset release directly to a screen position and derives
//   every expected output from the timing rules. Colour input is random,
//   address-derived or constant, and X while blanking.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vga_scan_gen;

    localparam int A_HS = 120, A_HB = 64, A_HA = 800, A_HF = 56;
    localparam int A_VS = 6,   A_VB = 23, A_VA = 600, A_VF = 37;
    localparam bit A_POL = 1'b1;
    localparam int A_HT = A_HS + A_HB + A_HA + A_HF;
    localparam int A_VT = A_VS + A_VB + A_VA + A_VF;

    localparam int B_HS = 8, B_HB = 4, B_HA = 16, B_HF = 4;
    localparam int B_VS = 2, B_VB = 3, B_VA = 5,  B_VF = 2;
    localparam bit B_POL = 1'b0;
    localparam int B_HT = B_HS + B_HB + B_HA + B_HF;
    localparam int B_VT = B_VS + B_VB + B_VA + B_VF;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vga_scan_gen_if bus_a ();
    vga_scan_gen_if bus_b ();

    vga_scan_gen dut_a (
        .sysclk (clk),
        .rst_n  (rst_n),
        .vga    (bus_a)
    );

    vga_scan_gen #(
        .H_SYNC(B_HS), .H_BACK(B_HB), .H_ACTIVE(B_HA), .H_FRONT(B_HF),
        .V_SYNC(B_VS), .V_BACK(B_VB), .V_ACTIVE(B_VA), .V_FRONT(B_VF),
        .SYNC_POL(B_POL)
    ) dut_b (
        .sysclk (clk),
        .rst_n  (rst_n),
        .vga    (bus_b)
    );

    int total = 0;
    int bad   = 0;
    int cnt   = 0;          // rising edges since reset release
    int mode  = 0;          // 0 random colour, 1 colour = x[2:0], 2 constant 101
    logic [2:0] data_a, data_b;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cnt=%0d)", tag, got, exp, cnt);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit is_active(int hs, int hb, int ha, int hf,
                                     int vs, int vb, int va, int vf, int n);
        int ht, vt, x, y;
        ht = hs + hb + ha + hf;
        vt = vs + vb + va + vf;
        x  = n % ht;
        y  = (n / ht) % vt;
        return (x >= hs + hb) && (x < hs + hb + ha) && (y >= vs + vb) && (y < vs + vb + va);
    endfunction

    // Outputs expected after the edge that consumed position n:
    // {hsync, vsync, r, g, b, frame_start}
    function automatic logic [5:0] model_out(int hs, int hb, int ha, int hf,
                                             int vs, int vb, int va, int vf,
                                             bit pol, int n, logic [2:0] data);
        int ht, vt, x, y;
        logic [2:0] rgb;
        logic hsy, vsy;
        ht = hs + hb + ha + hf;
        vt = vs + vb + va + vf;
        x  = n % ht;
        y  = (n / ht) % vt;
        rgb = 3'b000;
        if (is_active(hs, hb, ha, hf, vs, vb, va, vf, n)) begin
`ifdef VGA_TEST_PATTERN_EN
            rgb = 3'((x - (hs + hb)) / (ha / 8));
`else
            rgb = data;
`endif
        end
        hsy = (x < hs) ? pol : ~pol;
        vsy = (y < vs) ? pol : ~pol;
        return {hsy, vsy, rgb, (x == 0 && y == 0)};
    endfunction

    function automatic logic [21:0] model_addr(int ht, int vt, int n);
        return {11'(n % ht), 11'((n / ht) % vt)};
    endfunction

    function automatic logic [2:0] pick(int x, bit act);
        if (!act && $urandom_range(0, 1) == 1) return 3'bxxx;
        case (mode)
            0:       return 3'($urandom_range(0, 7));
            1:       return 3'(x % 8);
            default: return 3'b101;
        endcase
    endfunction

    function automatic logic [5:0] obs_a();
        return {bus_a.vga_hsync, bus_a.vga_vsync, bus_a.vga_r, bus_a.vga_g, bus_a.vga_b, bus_a.frame_start};
    endfunction

    function automatic logic [5:0] obs_b();
        return {bus_b.vga_hsync, bus_b.vga_vsync, bus_b.vga_r, bus_b.vga_g, bus_b.vga_b, bus_b.frame_start};
    endfunction

    // Present colour for the position the DUTs currently address (cnt).
    task automatic drive_data();
        if (cnt % 256 == 0) mode = $urandom_range(0, 2);
        data_a = pick(cnt % A_HT, is_active(A_HS, A_HB, A_HA, A_HF, A_VS, A_VB, A_VA, A_VF, cnt));
        data_b = pick(cnt % B_HT, is_active(B_HS, B_HB, B_HA, B_HF, B_VS, B_VB, B_VA, B_VF, cnt));
        bus_a.display_data = data_a;
        bus_b.display_data = data_b;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_out_a"}, 32'(obs_a()), 32'({~A_POL, ~A_POL, 3'b000, 1'b0}));
        check({tag, "_addr_a"}, 32'(bus_a.display_addr), 32'd0);
        check({tag, "_out_b"}, 32'(obs_b()), 32'({~B_POL, ~B_POL, 3'b000, 1'b0}));
        check({tag, "_addr_b"}, 32'(bus_b.display_addr), 32'd0);
    endtask

    // One clock: outputs reflect position cnt-1 with the colour driven then,
    // the address reflects position cnt.
    task automatic step();
        @(posedge clk);
        cnt++;
        @(negedge clk);
        check("out_a", 32'(obs_a()),
              32'(model_out(A_HS, A_HB, A_HA, A_HF, A_VS, A_VB, A_VA, A_VF, A_POL, cnt - 1, data_a)));
        check("addr_a", 32'(bus_a.display_addr), 32'(model_addr(A_HT, A_VT, cnt)));
        check("out_b", 32'(obs_b()),
              32'(model_out(B_HS, B_HB, B_HA, B_HF, B_VS, B_VB, B_VA, B_VF, B_POL, cnt - 1, data_b)));
        check("addr_b", 32'(bus_b.display_addr), 32'(model_addr(B_HT, B_VT, cnt)));
        drive_data();
    endtask

    int hs_hi, vs_hi, fs_b, end_cnt;

    initial begin
        bus_a.display_data = 3'b000;
        bus_b.display_data = 3'b000;
        data_a = 3'b000;
        data_b = 3'b000;

        // Reset held across several edges.
        repeat (3) @(negedge clk);
        check_reset("rst_init");

        cnt = 0;
        drive_data();
        rst_n = 1'b1;
        $display("phase reset_release cnt=%0d", cnt);

        // First line: hsync width on the default raster.
        hs_hi = 0;
        vs_hi = 0;
        fs_b  = 0;
        for (int i = 0; i < A_HT; i++) begin
            step();
            if (bus_a.vga_hsync == A_POL) hs_hi++;
            if (bus_a.vga_vsync == A_POL) vs_hi++;
            if (bus_b.frame_start) fs_b++;
        end
        check("hsync_width_a", 32'(hs_hi), 32'(A_HS));
        $display("phase first_line cnt=%0d hsync_clks=%0d", cnt, hs_hi);

        // Run to (500,30): covers vsync pulse, y=28/29 edges, many small frames.
        end_cnt = 30 * A_HT + 500;
        while (cnt < end_cnt) begin
            step();
            if (bus_a.vga_vsync == A_POL) vs_hi++;
            if (bus_b.frame_start) fs_b++;
        end
        check("vsync_width_a", 32'(vs_hi), 32'(A_VS * A_HT));
        check("frame_count_b", 32'(fs_b), 32'((cnt - 1) / (B_HT * B_VT) + 1));
        $display("phase run_to_mid cnt=%0d vsync_clks=%0d frames_b=%0d", cnt, vs_hi, fs_b);

        // Asynchronous reset mid-line, between clock edges.
        #2 rst_n = 1'b0;
        #1 check_reset("rst_async");
        @(negedge clk);
        check_reset("rst_held");
        cnt = 0;
        drive_data();
        rst_n = 1'b1;
        step();
        check("fs_after_rst_a", 32'(bus_a.frame_start), 32'd1);
        check("hsync_after_rst_a", 32'(bus_a.vga_hsync), 32'(A_POL));
        check("vsync_after_rst_a", 32'(bus_a.vga_vsync), 32'(A_POL));
        $display("phase mid_line_reset cnt=%0d", cnt);

        for (int i = 0; i < 3000; i++) step();
        $display("phase post_reset_run cnt=%0d", cnt);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
